// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: fetch front-end for the x86 decoder. It requests 64-byte lines
// from the I-cache, holds up to two consecutive lines and presents a decode window.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   redirect_valid, redirect_pc       flush the buffer and restart at a new PC
//   reqcyc, req, reqtag, reqack       line request (held until reqack)
//   respcyc, resp, resptag            single-cycle line response
//   win_valid, win_pc, win_bytes      registered decode window
//   consume_valid, consume_len        decoder retires bytes from the window
module fetch_line_buffer #(
  parameter int ADDR_W = 64,
  parameter int LINE_BYTES = 64,
  parameter int WIN_BYTES = 16,
  parameter int TAG_W = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       reqcyc,
  output logic [ADDR_W-1:0]          req,
  output logic [TAG_W-1:0]           reqtag,
  input  logic                       reqack,
  input  logic                       respcyc,
  input  logic [8*LINE_BYTES-1:0]    resp,
  input  logic [TAG_W-1:0]           resptag,
  output logic                       win_valid,
  output logic [ADDR_W-1:0]          win_pc,
  output logic [8*WIN_BYTES-1:0]     win_bytes,
  input  logic                       consume_valid,
  input  logic [$clog2(WIN_BYTES):0] consume_len
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WIN_W = 8 * WIN_BYTES;
  localparam int LEN_W = $clog2(WIN_BYTES) + 1;
  localparam int SPAN_W = OFF_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state;

  logic [1:0]             s_valid;
  logic [1:0][ADDR_W-1:0] s_base;
  logic [1:0][LINE_W-1:0] s_data;
  logic [ADDR_W-1:0]      fetch_addr;
  logic [TAG_W-1:0]       epoch;

  logic [1:0]             v_n;
  logic [1:0][ADDR_W-1:0] b_n;
  logic [1:0][LINE_W-1:0] d_n;
  logic [ADDR_W-1:0]      pc_n;
  logic [ADDR_W-1:0]      fa_n;
  logic [TAG_W-1:0]       ep_n;

  logic                   cons_ok;
  logic                   fill_ok;
  logic                   retire;
  logic [ADDR_W-1:0]      cons_pc;

  logic [OFF_W-1:0]       off;
  logic [2*LINE_W-1:0]    shifted;
  logic                   in0;
  logic                   spans;
  logic                   pair_ok;
  logic                   win_valid_n;
  logic [WIN_W-1:0]       win_bytes_n;

  function automatic logic [ADDR_W-1:0] line_of(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] r;
    r = a;
    r[OFF_W-1:0] = '0;
    return r;
  endfunction

  assign cons_ok = win_valid
                 && consume_valid
                 && (consume_len != '0)
                 && (consume_len <= LEN_W'(WIN_BYTES));

  assign cons_pc = win_pc + ADDR_W'(consume_len);

  // Once the PC leaves slot0's line, slot0 is dead.
  assign retire = cons_ok
                && (line_of(cons_pc) != s_base[0]);

  // Only a response carrying the live epoch may fill.
  assign fill_ok = (state == WAIT)
                 && respcyc
                 && (resptag == epoch)
                 && !redirect_valid;

  // Next slot/PC state: redirect dominates, else
  // consume+shift first, then fill the lowest free
  // slot of the shifted buffer.
  always_comb begin
    v_n  = s_valid;
    b_n  = s_base;
    d_n  = s_data;
    pc_n = win_pc;
    fa_n = fetch_addr;
    ep_n = epoch;
    if (redirect_valid) begin
      v_n  = '0;
      pc_n = redirect_pc;
      fa_n = line_of(redirect_pc);
      ep_n = epoch + TAG_W'(1);
    end else begin
      if (cons_ok) begin
        pc_n = cons_pc;
      end
      if (retire) begin
        v_n[0] = s_valid[1];
        b_n[0] = s_base[1];
        d_n[0] = s_data[1];
        v_n[1] = 1'b0;
      end
      if (fill_ok) begin
        if (!v_n[0]) begin
          v_n[0] = 1'b1;
          b_n[0] = fetch_addr;
          d_n[0] = resp;
        end else begin
          v_n[1] = 1'b1;
          b_n[1] = fetch_addr;
          d_n[1] = resp;
        end
        fa_n = fetch_addr + ADDR_W'(LINE_BYTES);
      end
    end
  end

  // Window from the next state so it shows up
  // one edge after the fill or consume.
  assign off = pc_n[OFF_W-1:0];
  assign shifted = d_n >> {off, 3'b000};
  assign win_bytes_n = shifted[WIN_W-1:0];

  assign in0 = v_n[0]
             && (line_of(pc_n) == b_n[0]);

  assign spans = ({2'b00, off} + SPAN_W'(WIN_BYTES))
               > SPAN_W'(LINE_BYTES);

  assign pair_ok = v_n[1]
                 && (b_n[1] == b_n[0] + ADDR_W'(LINE_BYTES));

  assign win_valid_n = in0 && (!spans || pair_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_valid    <= '0;
      s_base     <= '0;
      s_data     <= '0;
      fetch_addr <= line_of(RESET_PC);
      epoch      <= '0;
      win_pc     <= RESET_PC;
      win_valid  <= 1'b0;
      win_bytes  <= '0;
    end else begin
      s_valid    <= v_n;
      s_base     <= b_n;
      s_data     <= d_n;
      fetch_addr <= fa_n;
      epoch      <= ep_n;
      win_pc     <= pc_n;
      win_valid  <= win_valid_n;
      win_bytes  <= win_bytes_n;
    end
  end

  // One request in flight at most; a request
  // already on the bus is never withdrawn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      reqcyc <= 1'b0;
      req    <= '0;
      reqtag <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!(&s_valid) && !redirect_valid) begin
            req    <= fetch_addr;
            reqtag <= epoch;
            reqcyc <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (reqack) begin
            reqcyc <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (respcyc) begin
            state <= IDLE;
          end
        end
        default: begin
          reqcyc <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb_fetch_line_buffer: directed bench for fetch_line_buffer.
// Expected requests/windows are queued by stimulus and checked by a monitor.
module tb_fetch_line_buffer;

  localparam int AW = 64;
  localparam int LB = 64;
  localparam int WB = 16;
  localparam int TW = 13;
  localparam int LW = $clog2(WB) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [AW-1:0]   redirect_pc = '0;
  logic            reqcyc;
  logic [AW-1:0]   req;
  logic [TW-1:0]   reqtag;
  logic            reqack = 1'b0;
  logic            respcyc = 1'b0;
  logic [8*LB-1:0] resp = '0;
  logic [TW-1:0]   resptag = '0;
  logic            win_valid;
  logic [AW-1:0]   win_pc;
  logic [8*WB-1:0] win_bytes;
  logic            consume_valid = 1'b0;
  logic [LW-1:0]   consume_len = '0;

  always #5 clk = ~clk;

  fetch_line_buffer #(
    .RESET_PC(64'h1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .reqcyc(reqcyc),
    .req(req),
    .reqtag(reqtag),
    .reqack(reqack),
    .respcyc(respcyc),
    .resp(resp),
    .resptag(resptag),
    .win_valid(win_valid),
    .win_pc(win_pc),
    .win_bytes(win_bytes),
    .consume_valid(consume_valid),
    .consume_len(consume_len)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [TW-1:0] t;
  } req_t;

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [8*WB-1:0] b;
  } win_t;

  req_t rq[$];
  win_t wq[$];
  int   vecs = 0;
  int   bad = 0;

  function automatic logic [7:0] pat(logic [AW-1:0] a);
    return a[7:0] ^ (a[15:8] - 8'h10);
  endfunction

  function automatic logic [8*LB-1:0] line_data(logic [AW-1:0] b);
    logic [8*LB-1:0] d;
    for (int i = 0; i < LB; i++) d[8*i +: 8] = pat(b + AW'(i));
    return d;
  endfunction

  function automatic logic [8*WB-1:0] win_of(logic [AW-1:0] pc);
    logic [8*WB-1:0] d;
    for (int i = 0; i < WB; i++) d[8*i +: 8] = pat(pc + AW'(i));
    return d;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: checks every accepted request and every new valid window.
  logic            pv = 1'b0;
  logic [AW-1:0]   ppc = '0;
  logic [8*WB-1:0] pb = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reqcyc && reqack) begin
        if (rq.size() == 0) begin
          vecs++;
          bad++;
          $display("FAIL req_unexpected got %h/%h", req, reqtag);
        end else begin
          req_t e;
          e = rq.pop_front();
          chk("req_addr", 128'(req), 128'(e.a));
          chk("req_tag", 128'(reqtag), 128'(e.t));
        end
      end
      if (win_valid && (!pv || win_pc != ppc || win_bytes != pb)) begin
        if (wq.size() == 0) begin
          vecs++;
          bad++;
          $display("FAIL win_unexpected got %h %h", win_pc, win_bytes);
        end else begin
          win_t w;
          w = wq.pop_front();
          chk("win_pc", 128'(win_pc), 128'(w.pc));
          chk("win_bytes", win_bytes, w.b);
        end
      end
      pv  = win_valid;
      ppc = win_pc;
      pb  = win_bytes;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rc();
    int k = 0;
    while (!reqcyc && k < 50) begin
      step();
      k++;
    end
    if (!reqcyc) begin
      vecs++;
      bad++;
      $display("FAIL req_timeout got reqcyc=0 want 1");
    end
  endtask

  task automatic get_req(logic [AW-1:0] a, logic [TW-1:0] t);
    req_t e;
    e.a = a;
    e.t = t;
    wait_rc();
    if (reqcyc) begin
      rq.push_back(e);
      reqack = 1'b1;
      step();
      reqack = 1'b0;
    end
  endtask

  task automatic respond(logic [AW-1:0] b, logic [TW-1:0] t);
    respcyc = 1'b1;
    resp    = line_data(b);
    resptag = t;
    step();
    respcyc = 1'b0;
  endtask

  task automatic consume(int len);
    consume_valid = 1'b1;
    consume_len   = LW'(len);
    step();
    consume_valid = 1'b0;
  endtask

  task automatic redirect(logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic exp_win(logic [AW-1:0] pc, logic [8*WB-1:0] b);
    win_t w;
    w.pc = pc;
    w.b  = b;
    wq.push_back(w);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_reqcyc"}, 128'(reqcyc), 128'(0));
    chk({tag, "_req"}, 128'(req), 128'(0));
    chk({tag, "_reqtag"}, 128'(reqtag), 128'(0));
    chk({tag, "_win_valid"}, 128'(win_valid), 128'(0));
    chk({tag, "_win_pc"}, 128'(win_pc), 128'h1000);
    chk({tag, "_win_bytes"}, win_bytes, 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    // Reset values
    #1 reset_n = 1'b0;
    #1 chk_reset("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Test 1: first line
    step();
    chk("rst_to_reqcyc", 128'(reqcyc), 128'(1));
    get_req(64'h1000, 0);
    exp_win(64'h1000, 128'h0F0E0D0C0B0A09080706050403020100);
    respond(64'h1000, 0);
    chk("fill_win_valid", 128'(win_valid), 128'(1));

    // Test 3: consume, illegal lengths, retire
    consume(0);
    chk("consume_len0", 128'(win_pc), 128'h1000);
    consume(17);
    chk("consume_len17", 128'(win_pc), 128'h1000);
    exp_win(64'h1005, win_of(64'h1005));
    consume(5);
    chk("consume5_pc", 128'(win_pc), 128'h1005);
    get_req(64'h1040, 0);
    respond(64'h1040, 0);
    for (int i = 1; i <= 4; i++) begin
      exp_win(64'h1005 + AW'(16 * i), win_of(64'h1005 + AW'(16 * i)));
      consume(16);
    end
    chk("retire_pc", 128'(win_pc), 128'h1045);
    chk("retire_valid", 128'(win_valid), 128'(1));
    get_req(64'h1080, 0);

    // Test 4: redirect while waiting, stale response dropped
    redirect(64'h3000);
    chk("redir_flush", 128'(win_valid), 128'(0));
    consume(4);
    chk("consume_invalid", 128'(win_pc), 128'h3000);
    respond(64'h1080, 0);
    chk("stale_drop", 128'(win_valid), 128'(0));
    get_req(64'h3000, 1);
    exp_win(64'h3000, win_of(64'h3000));
    respond(64'h3000, 1);
    chk("t4_valid", 128'(win_valid), 128'(1));
    chk("t4_pc", 128'(win_pc), 128'h3000);

    // Test 2: redirect while REQ held, straddling window
    wait_rc();
    redirect(64'h2038);
    chk("hold_reqcyc", 128'(reqcyc), 128'(1));
    chk("hold_req", 128'(req), 128'h3040);
    chk("hold_tag", 128'(reqtag), 128'(1));
    get_req(64'h3040, 1);
    respond(64'h3040, 1);
    chk("t2_stale", 128'(win_valid), 128'(0));
    get_req(64'h2000, 2);
    respond(64'h2000, 2);
    chk("t2_half", 128'(win_valid), 128'(0));
    get_req(64'h2040, 2);
    exp_win(64'h2038, win_of(64'h2038));
    respond(64'h2040, 2);
    chk("t2_valid", 128'(win_valid), 128'(1));
    chk("t2_bytes", win_bytes, 128'h57565554535251502F2E2D2C2B2A2928);

    // Test 5: full buffer issues nothing
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (reqcyc) hi++;
    end
    chk("full_no_req", 128'(hi), 128'(0));
    exp_win(64'h2040, win_of(64'h2040));
    consume(8);
    get_req(64'h2080, 2);

    // Test 6: async reset in WAIT, early response ignored
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset("async");
    step();
    reset_n = 1'b1;
    step();
    chk("rst2_reqcyc", 128'(reqcyc), 128'(1));
    respond(64'h1000, 0);
    chk("early_resp", 128'(win_valid), 128'(0));
    get_req(64'h1000, 0);
    exp_win(64'h1000, win_of(64'h1000));
    respond(64'h1000, 0);
    chk("t6_valid", 128'(win_valid), 128'(1));

    step(3);
    chk("req_queue_empty", 128'(rq.size()), 128'(0));
    chk("win_queue_empty", 128'(wq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
